// File: rtl/pmem_line_responder_if.sv
// Line-level miss interface between the cache controller (master) and the
// physical-memory responder (slave).
interface pmem_line_responder_if #(
  parameter int LINE_BITS = 256
) ();
  logic                 mem_read;
  logic                 mem_write;
  logic [31:0]          mem_address;
  logic [LINE_BITS-1:0] mem_wdata;
  logic [LINE_BITS-1:0] mem_rdata;
  logic                 mem_resp;
  logic                 proto_err;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp,
    input  proto_err
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp,
    output proto_err
  );
endinterface

// File: rtl/pmem_line_responder.sv
// Fixed-latency cacheline memory answering the cache's line miss interface.
// Defining PMEM_RANDOM_LATENCY_EN adds 0..7 LFSR-chosen extra cycles per request.
module pmem_line_responder #(
  parameter int LATENCY    = 10,
  parameter int INDEX_BITS = 8,
  parameter int LINE_BITS  = 256
) (
  input logic                 clk,
  input logic                 rst,
  pmem_line_responder_if.slave bus
);

  localparam int         DEPTH     = 1 << INDEX_BITS;
  localparam logic [8:0] LOAD_BASE = 9'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_r;
  logic [8:0]            count_r;
  logic                  op_write_r;
  logic [INDEX_BITS-1:0] index_r;
  logic [LINE_BITS-1:0]  wdata_r;
  logic [LINE_BITS-1:0]  rdata_r;
  logic                  resp_r;
  logic                  proto_err_r;
  logic [LINE_BITS-1:0]  line_array [DEPTH];

  logic [INDEX_BITS-1:0] req_index_s;
  logic [INDEX_BITS-1:0] rd_index_s;
  logic [LINE_BITS-1:0]  rd_line_s;
  logic                  both_s;
  logic                  accept_s;
  logic                  abort_s;
  logic                  wr_en_s;
  logic [8:0]            load_s;

  // Request decode, protocol-violation detection and array read port
  always_comb begin
    req_index_s = bus.mem_address[5 +: INDEX_BITS];
    both_s      = bus.mem_read & bus.mem_write;
    accept_s    = bus.mem_read ^ bus.mem_write;
    if (op_write_r) begin
      abort_s = ~bus.mem_write | bus.mem_read;
    end else begin
      abort_s = ~bus.mem_read | bus.mem_write;
    end
    // With a one-cycle load the read happens in IDLE, before index_r is valid
    if (state_r == IDLE) begin
      rd_index_s = req_index_s;
    end else begin
      rd_index_s = index_r;
    end
    rd_line_s = line_array[rd_index_s];
    wr_en_s   = (state_r == RESP) & op_write_r & ~rst;
  end

`ifdef PMEM_RANDOM_LATENCY_EN
  logic [7:0] lfsr_r;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Latency jitter source, stepped once per accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= 8'hA5;
    end else if ((state_r == IDLE) && accept_s) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign load_s = LOAD_BASE + {6'd0, lfsr_r[2:0]};
`else
  assign load_s = LOAD_BASE;
`endif

  // Transaction FSM with registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= 9'd0;
      op_write_r  <= 1'b0;
      index_r     <= {INDEX_BITS{1'b0}};
      wdata_r     <= {LINE_BITS{1'b0}};
      rdata_r     <= {LINE_BITS{1'b0}};
      resp_r      <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          resp_r  <= 1'b0;
          rdata_r <= {LINE_BITS{1'b0}};
          if (both_s) begin
            proto_err_r <= 1'b1;
          end else if (accept_s) begin
            op_write_r <= bus.mem_write;
            index_r    <= req_index_s;
            wdata_r    <= bus.mem_wdata;
            if (load_s == 9'd0) begin
              state_r <= RESP;
              count_r <= 9'd0;
              resp_r  <= 1'b1;
              rdata_r <= bus.mem_write ? {LINE_BITS{1'b0}} : rd_line_s;
            end else begin
              state_r <= WAIT;
              count_r <= load_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (abort_s) begin
            proto_err_r <= 1'b1;
            state_r     <= IDLE;
            count_r     <= 9'd0;
          end else if (count_r == 9'd1) begin
            state_r <= RESP;
            count_r <= 9'd0;
            resp_r  <= 1'b1;
            rdata_r <= op_write_r ? {LINE_BITS{1'b0}} : rd_line_s;
          end else begin
            count_r <= count_r - 9'd1;
          end
        end
        RESP: begin
          state_r <= IDLE;
          resp_r  <= 1'b0;
          rdata_r <= {LINE_BITS{1'b0}};
        end
        default: begin
          state_r <= IDLE;
          count_r <= 9'd0;
          resp_r  <= 1'b0;
          rdata_r <= {LINE_BITS{1'b0}};
        end
      endcase
    end
  end

  // Line storage; written at the end of a write's response cycle only
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      line_array[index_r] <= wdata_r;
    end
  end

  assign bus.mem_rdata = rdata_r;
  assign bus.mem_resp  = resp_r;
  assign bus.proto_err = proto_err_r;

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Simulation/synthesisable physical-memory responder for the cache's line-level miss interface.
- Accepts one 256-bit cacheline read or write from the cache controller (mem_read/mem_write/mem_address/mem_wdata).
- Returns mem_rdata with a single-cycle mem_resp after a fixed latency, backed by an internal line array.
- Sits below the cache, in place of the cacheline adaptor plus DRAM model, for cache-level verification and small FPGA builds.

Parameters:
- LATENCY, 10, cycles from request acceptance to the mem_resp pulse; legal range 1..255.
- INDEX_BITS, 8, number of line-index bits; the array holds 2**INDEX_BITS lines.
- LINE_BITS, 256, cacheline width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_read  input  1  line read request; held by the initiator until mem_resp.
- mem_write  input  1  line write request; held by the initiator until mem_resp.
- mem_address  input  32  byte address; bits [4:0] ignored; index = mem_address[5+INDEX_BITS-1:5].
- mem_wdata  input  LINE_BITS  write line.
- mem_rdata  output  LINE_BITS  read line; valid only while mem_resp=1.
- mem_resp  output  1  one-cycle completion pulse.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rst=1): state=IDLE, mem_resp=0, mem_rdata=0, proto_err=0, counter=0. Array contents are not reset.
- Reset mid-operation aborts the transaction; no array write is performed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Exactly one of mem_read/mem_write high in cycle T: latch op, index, wdata; load counter=LATENCY-1; go to WAIT, or to RESP if LATENCY=1.
  - Both high: set proto_err, stay IDLE, accept nothing.
  - Neither high: stay IDLE.
- WAIT:
  - Decrement the counter each cycle; go to RESP when the counter reaches 0.
  - If the latched op's request line drops, or the opposite line rises, before RESP: set proto_err, return to IDLE, no array write.
- RESP: lasts exactly one cycle, which is cycle T+LATENCY.
  - mem_resp=1.
  - Read: mem_rdata = array[index] as registered in the same cycle.
  - Write: array[index] <= latched wdata at the end of this cycle; mem_rdata=0.
  - Next state is always IDLE.
- Back-to-back: IDLE may accept a new request in the cycle immediately after RESP. The cache's write-back-then-fill sequence (write resp, read asserted next cycle) costs exactly LATENCY+1 cycles per transaction.
- Read-after-write to the same index returns the newly written line.
- mem_rdata is 0 in every cycle where mem_resp=0.
- Address bits above the index alias; this is not an error.
- Changes to mem_address or mem_wdata after acceptance are ignored (latched at T).

Optional Feature:
- Macro: PMEM_RANDOM_LATENCY_EN.
- Defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset value 8'hA5, advanced once per accepted request.
  - Extra delay = LFSR[2:0], sampled before the advance; counter loads LATENCY-1+extra.
  - Response cycle becomes T+LATENCY+extra (0..7 extra cycles).
- Undefined: no LFSR logic; latency is exactly LATENCY.

Test Plan:
1. Reset, then write 0x...DEADBEEF line to address 0x0000_0120 (index 9), LATENCY=10 -> mem_resp high only at T+10; read of 0x0000_013F then returns the identical line at its T+10.
2. Write index 3 then read index 3 in the cycle right after the write's resp -> read mem_resp at T'+10 with the new data; no idle gap is required between transactions.
3. mem_read and mem_write both high in IDLE -> proto_err=1, mem_resp never pulses, array unchanged; proto_err clears only on rst.
4. Write started, rst asserted at T+4 -> outputs 0 immediately (async); a subsequent read of that index returns the old contents.
5. mem_read dropped at T+5 -> proto_err=1, state IDLE, no mem_resp; a new read at T+7 completes at T+17.
6. With PMEM_RANDOM_LATENCY_EN, first request after reset -> extra=5 (A5[2:0]); mem_resp at T+LATENCY+5.
